latch_pattern_driver: RTL

//  Drives a serial D stimulus into a latch/flip-flop under test, one pattern bit per HOLD

---
 rtl/latch_pattern_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/latch_pattern_driver.sv
// latch_pattern_driver
//   Serial stimulus generator for a latch or flip-flop under test. A captured
//   pattern is emitted MSB first on D, each bit held for HOLD clock cycles,
//   and the whole pattern is emitted REPEAT+1 times.
//
//   Optional feature macro: PATTERN_CHECK_EN
//     defined   : Q is compared with D on the last held cycle of every bit;
//                 mismatches are counted in ERR_CNT (saturating at 255).
//     undefined : no checker logic, ERR_CNT is constant 0, Q is ignored.
//
//   Handshake: START is sampled only in IDLE; an accepted START captures
//   PATTERN and REPEAT, raises BUSY on the same edge and puts the first bit
//   on D. BUSY stays high for (REPEAT+1)*WIDTH*HOLD cycles, then DONE pulses
//   for exactly one cycle (FIN) and the block returns to IDLE. START, PATTERN
//   and REPEAT are don't-care while BUSY or DONE is high.
//
// Ports
//   CK       in   clock, rising edge
//   RST      in   asynchronous reset, active-high
//   START    in   start request
//   PATTERN  in   [WIDTH-1:0]    pattern to emit
//   REPEAT   in   [REPEAT_W-1:0] extra passes, 0 = emit once
//   Q        in   output of the device under test (checker only)
//   D        out  serial stimulus
//   BUSY     out  high while the pattern is being emitted
//   DONE     out  one-cycle pulse after the last bit
//   ERR_CNT  out  [7:0] Q/D mismatch count
module latch_pattern_driver #(
    parameter int WIDTH    = 8,
    parameter int HOLD     = 2,
    parameter int REPEAT_W = 4
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                START,
    input  logic [WIDTH-1:0]    PATTERN,
    input  logic [REPEAT_W-1:0] REPEAT,
    input  logic                Q,
    output logic                D,
    output logic                BUSY,
    output logic                DONE,
    output logic [7:0]          ERR_CNT
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    pat_reg;
    logic [WIDTH-1:0]    shreg;
    logic [REPEAT_W-1:0] rep_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [HOLD_W-1:0]   hold_cnt;

    // D is the MSB of the shift register. The register is loaded on START and
    // on every repeat, shifted per bit, and cleared when the run ends, so D is
    // a plain flop output that reads 0 whenever the block is not emitting.
    assign D = shreg[WIDTH-1];

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pat_reg  <= '0;
            shreg    <= '0;
            rep_cnt  <= '0;
            bit_idx  <= '0;
            hold_cnt <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    BUSY <= 1'b0;
                    if (START) begin
                        pat_reg  <= PATTERN;
                        shreg    <= PATTERN;
                        rep_cnt  <= REPEAT;
                        bit_idx  <= '0;
                        hold_cnt <= '0;
                        BUSY     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hold_cnt != LAST_HOLD) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        hold_cnt <= '0;
                        if (bit_idx != LAST_IDX) begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        end else if (rep_cnt != '0) begin
                            // Counting down from the captured value gives
                            // exactly REPEAT extra passes, all-ones included.
                            rep_cnt <= rep_cnt - REPEAT_W'(1);
                            bit_idx <= '0;
                            shreg   <= pat_reg;
                        end else begin
                            shreg <= '0;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    shreg <= '0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PATTERN_CHECK_EN
    logic [7:0] err_cnt;

    // Q is compared on the last held cycle of each bit, giving the device
    // under test the longest settling time the hold window allows.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            err_cnt <= '0;
        end else if (state == IDLE && START) begin
            err_cnt <= '0;
        end else if (state == SHIFT && hold_cnt == LAST_HOLD &&
                     Q != D && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = err_cnt;
`else
    logic unused_q;
    assign unused_q = Q;
    assign ERR_CNT  = 8'd0;
`endif

endmodule
